// File: rtl/msg_scroll_pkg.sv
// Shared types and constants for the three-digit message scroller.
// Holds the FSM state encoding, character/window geometry and the default blank code.
// Also provides the modular index helpers used by the scroller datapath.
package msg_scroll_pkg;

    // Character and window geometry
    localparam int CHAR_W = 5;
    localparam int DIGITS = 3;
    localparam int WIN_W  = CHAR_W * DIGITS;
    localparam int IDX_W  = 4;

    // Code shown in digit positions that have not been filled yet
    localparam logic [CHAR_W-1:0] DEFAULT_BLANK = 5'h1F;

    // Scroll FSM: idle until a prescaler tick, then one fetch and one shift cycle
    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SHIFT = 2'd2
    } state_e;

    // Scroll direction as latched for a step
    typedef enum logic {
        DIR_FWD = 1'b0,
        DIR_REV = 1'b1
    } dir_e;

    // Next ROM address, wrapping modulo len in either direction
    function automatic logic [IDX_W-1:0] step_index(
        input logic [IDX_W-1:0] idx,
        input dir_e             dir,
        input int unsigned      len
    );
        logic [IDX_W-1:0] last;
        last = IDX_W'(len - 1);
        if (dir == DIR_REV) begin
            return (idx == '0) ? last : idx - 1'b1;
        end
        return (idx == last) ? '0 : idx + 1'b1;
    endfunction

    // True when moving from idx in direction dir crosses the ROM boundary
    function automatic logic crosses_end(
        input logic [IDX_W-1:0] idx,
        input dir_e             dir,
        input int unsigned      len
    );
        if (dir == DIR_REV) begin
            return (idx == '0);
        end
        return (idx == IDX_W'(len - 1));
    endfunction

endpackage

// File: rtl/scroll_tick_gen.sv
// Scroll-rate prescaler: counts enabled clk cycles 0..TICK_DIV-1 and flags the last one.
// Latency: tick is combinational from the count register, high in the cycle the count is TICK_DIV-1.
// Backpressure: en low freezes the count (no tick); it resumes from the held value.
module scroll_tick_gen #(
    parameter int TICK_DIV = 3000000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int              CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_last;

    assign at_last = (cnt_q == LAST);

    // A tick only fires on a cycle that actually advances the count
    assign tick = en && at_last;

    // Advance while enabled, roll over after the last count, hold otherwise
    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = at_last ? '0 : cnt_q + 1'b1;
        end
    end

    // Count register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/message_scroller.sv
// Scrolls a MSG_LEN-character ROM message through a three-digit window, one step per prescaler tick.
// Latency: tick -> FETCH -> SHIFT; window/rom_index/step_pulse/wrap update at the end of SHIFT.
// Backpressure: en low pauses the prescaler only; a step already in FETCH/SHIFT always completes.
// Build option: define MSG_SCROLL_BOUNCE_EN to ping-pong between the message ends instead of using dir.
module message_scroller
    import msg_scroll_pkg::*;
#(
    parameter int                MSG_LEN  = 10,
    parameter int                TICK_DIV = 3000000,
    parameter logic [CHAR_W-1:0] BLANK    = DEFAULT_BLANK
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              dir,
    output logic [IDX_W-1:0]  rom_index,
    input  logic [CHAR_W-1:0] rom_value,
    output logic [WIN_W-1:0]  window,
    output logic              step_pulse,
    output logic              wrap
);

    logic             tick;
    state_e           state_q;
    dir_e             dir_q;      // direction frozen for the step in progress
    dir_e             dir_src;    // where FETCH takes the direction from
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;
    logic [WIN_W-1:0] win_q;
    logic [WIN_W-1:0] win_d;
    logic             step_q;
    logic             wrap_q;
    logic             wrap_d;

    scroll_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .tick  (tick)
    );

`ifdef MSG_SCROLL_BOUNCE_EN
    // Bounce mode: direction is owned internally and flips at each message end
    dir_e bounce_q;
    logic bounce_flip;

    assign dir_src = bounce_q;

    // Turn around when the new address lands on the end we were heading for
    always_comb begin
        bounce_flip = (dir_q == DIR_REV) ? (idx_d == '0)
                                         : (idx_d == IDX_W'(MSG_LEN - 1));
    end

    assign wrap_d = bounce_flip;

    // Internal direction bit, toggled in SHIFT on reaching an end
    always_ff @(posedge clk) begin
        if (reset) begin
            bounce_q <= DIR_FWD;
        end else if (state_q == ST_SHIFT && bounce_flip) begin
            bounce_q <= (bounce_q == DIR_FWD) ? DIR_REV : DIR_FWD;
        end
    end
`else
    // Free-running mode: direction comes from the dir pin, sampled in FETCH
    assign dir_src = dir_e'(dir);
    assign wrap_d  = crosses_end(idx_q, dir_q, MSG_LEN);
`endif

    // Next window and address for the SHIFT cycle; rom_value is the char at idx_q
    always_comb begin
        idx_d = step_index(idx_q, dir_q, MSG_LEN);
        if (dir_q == DIR_REV) begin
            win_d = {rom_value, win_q[WIN_W-1:CHAR_W]};
        end else begin
            win_d = {win_q[WIN_W-CHAR_W-1:0], rom_value};
        end
    end

    // Scroll FSM with registered outputs; reset wins over any step in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_WAIT;
            dir_q   <= DIR_FWD;
            idx_q   <= '0;
            win_q   <= {DIGITS{BLANK}};
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            step_q <= 1'b0;
            wrap_q <= 1'b0;
            case (state_q)
                ST_WAIT: begin
                    if (tick) begin
                        state_q <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    dir_q   <= dir_src;
                    state_q <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    win_q   <= win_d;
                    idx_q   <= idx_d;
                    step_q  <= 1'b1;
                    wrap_q  <= wrap_d;
                    state_q <= ST_WAIT;
                end
                default: begin
                    state_q <= ST_WAIT;
                end
            endcase
        end
    end

    assign rom_index  = idx_q;
    assign window     = win_q;
    assign step_pulse = step_q;
    assign wrap       = wrap_q;

endmodule

// File: tb/tb_message_scroller.sv
// Self-checking bench for message_scroller (TICK_DIV=4, MSG_LEN=10, ROM returns its own address).
// Directed vector table, hand-written multi-cycle corner sequences, then randomized traffic vs a model.
module tb_message_scroller;

    localparam int MSG_LEN  = 10;
    localparam int TICK_DIV = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        dir;
    logic [3:0]  rom_index;
    logic [4:0]  rom_value;
    logic [14:0] window;
    logic        step_pulse;
    logic        wrap;

    assign rom_value = {1'b0, rom_index};

    always #5 clk = ~clk;

    message_scroller #(
        .MSG_LEN  (MSG_LEN),
        .TICK_DIV (TICK_DIV),
        .BLANK    (5'h1F)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .dir        (dir),
        .rom_index  (rom_index),
        .rom_value  (rom_value),
        .window     (window),
        .step_pulse (step_pulse),
        .wrap       (wrap)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a step is a scheduled event two edges after its tick;
    // the tick is every TICK_DIV-th enabled edge since reset.
    longint m_edge     = 0;
    longint m_fetch_at = -1;
    longint m_shift_at = -1;
    int     m_en_cnt   = 0;
    int     m_idx      = 0;
    int     m_win[3]   = '{31, 31, 31};
    bit     m_dir      = 1'b0;
    bit     m_sp       = 1'b0;
    bit     m_wr       = 1'b0;

    task automatic model_edge(input bit r, input bit e, input bit d);
        m_edge++;
        m_sp = 1'b0;
        m_wr = 1'b0;
        if (r) begin
            m_en_cnt   = 0;
            m_fetch_at = -1;
            m_shift_at = -1;
            m_idx      = 0;
            m_win      = '{31, 31, 31};
            m_dir      = 1'b0;
        end else begin
            if (m_edge == m_fetch_at) m_dir = d;
            if (m_edge == m_shift_at) begin
                if (!m_dir) begin
                    m_win[2] = m_win[1];
                    m_win[1] = m_win[0];
                    m_win[0] = m_idx;
                    m_idx    = (m_idx + 1) % MSG_LEN;
                    m_wr     = (m_idx == 0);
                end else begin
                    m_win[0] = m_win[1];
                    m_win[1] = m_win[2];
                    m_win[2] = m_idx;
                    m_idx    = (m_idx + MSG_LEN - 1) % MSG_LEN;
                    m_wr     = (m_idx == MSG_LEN - 1);
                end
                m_sp = 1'b1;
            end
            if (e) begin
                m_en_cnt++;
                if (m_en_cnt % TICK_DIV == 0) begin
                    m_fetch_at = m_edge + 1;
                    m_shift_at = m_edge + 2;
                end
            end
        end
    endtask

    function automatic logic [20:0] model_pack();
        return {5'(m_win[2]), 5'(m_win[1]), 5'(m_win[0]), 4'(m_idx), m_sp, m_wr};
    endfunction

    // Apply inputs for one rising edge, advance the model, sample 1ns after the edge
    task automatic step(input bit r, input bit e, input bit d);
        reset = r;
        en    = e;
        dir   = d;
        @(posedge clk);
        model_edge(r, e, d);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        bit          rst;
        bit          en;
        bit          dir;
        int          n;
        logic [14:0] win;
        logic [3:0]  idx;
        bit          sp;
        bit          wr;
    } vec_t;

    localparam int NV = 17;
    vec_t vt[NV];

    initial begin
        int seen;
        int first;
        bit rr;
        bit re;
        bit rd;

        reset = 1'b1;
        en    = 1'b0;
        dir   = 1'b0;

        //           rst en dir  n   window    idx   sp wr
        vt[0]  = '{1'b1, 1'b0, 1'b0,  2, 15'h7FFF, 4'd0, 1'b0, 1'b0};
        vt[1]  = '{1'b0, 1'b1, 1'b0,  5, 15'h7FFF, 4'd0, 1'b0, 1'b0};
        vt[2]  = '{1'b0, 1'b1, 1'b0,  1, 15'h7FE0, 4'd1, 1'b1, 1'b0};
        vt[3]  = '{1'b0, 1'b1, 1'b0,  4, 15'h7C01, 4'd2, 1'b1, 1'b0};
        vt[4]  = '{1'b0, 1'b1, 1'b0,  4, 15'h0022, 4'd3, 1'b1, 1'b0};
        vt[5]  = '{1'b0, 1'b1, 1'b0,  1, 15'h0022, 4'd3, 1'b0, 1'b0};
        vt[6]  = '{1'b0, 1'b1, 1'b0, 26, 15'h18E8, 4'd9, 1'b0, 1'b0};
        vt[7]  = '{1'b0, 1'b1, 1'b0,  1, 15'h1D09, 4'd0, 1'b1, 1'b1};
        vt[8]  = '{1'b0, 1'b1, 1'b0,  1, 15'h1D09, 4'd0, 1'b0, 1'b0};
        vt[9]  = '{1'b1, 1'b1, 1'b0,  1, 15'h7FFF, 4'd0, 1'b0, 1'b0};
        vt[10] = '{1'b0, 1'b1, 1'b1,  6, 15'h03FF, 4'd9, 1'b1, 1'b1};
        vt[11] = '{1'b0, 1'b1, 1'b1,  4, 15'h241F, 4'd8, 1'b1, 1'b0};
        vt[12] = '{1'b0, 1'b1, 1'b1,  1, 15'h241F, 4'd8, 1'b0, 1'b0};
        // dir flipped to forward while waiting: next step goes forward
        vt[13] = '{1'b0, 1'b1, 1'b0,  3, 15'h03E8, 4'd9, 1'b1, 1'b0};
        // dir=1 through FETCH, then flipped at the SHIFT edge: step stays reverse
        vt[14] = '{1'b0, 1'b1, 1'b1,  2, 15'h03E8, 4'd9, 1'b0, 1'b0};
        vt[15] = '{1'b0, 1'b1, 1'b1,  1, 15'h03E8, 4'd9, 1'b0, 1'b0};
        vt[16] = '{1'b0, 1'b1, 1'b0,  1, 15'h241F, 4'd8, 1'b1, 1'b0};

        for (int i = 0; i < NV; i++) begin
            for (int c = 0; c < vt[i].n; c++) step(vt[i].rst, vt[i].en, vt[i].dir);
            chk($sformatf("vec%0d.window", i),     32'(window),     32'(vt[i].win));
            chk($sformatf("vec%0d.rom_index", i),  32'(rom_index),  32'(vt[i].idx));
            chk($sformatf("vec%0d.step_pulse", i), 32'(step_pulse), 32'(vt[i].sp));
            chk($sformatf("vec%0d.wrap", i),       32'(wrap),       32'(vt[i].wr));
        end

        // Pause mid-count: two enabled edges, 20 disabled, then resume
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            step(1'b0, 1'b0, 1'b0);
            seen += int'(step_pulse);
        end
        chk("pause.no_pulse", 32'(seen), 32'd0);
        chk("pause.window_held", 32'(window), 32'h7FFF);
        first = -1;
        for (int k = 1; k <= 8; k++) begin
            step(1'b0, 1'b1, 1'b0);
            if (step_pulse && first < 0) first = k;
        end
        chk("pause.resume_edges_to_pulse", 32'(first), 32'd4);

        // en dropped right after the tick: the step still completes
        step(1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("endrop.fetch_no_pulse", 32'(step_pulse), 32'd0);
        step(1'b0, 1'b0, 1'b0);
        chk("endrop.pulse", 32'(step_pulse), 32'd1);
        chk("endrop.window", 32'(window), 32'h7FE0);

        // Reset while in FETCH: outputs reset, no orphan pulse afterwards
        step(1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("rstfetch.window", 32'(window), 32'h7FFF);
        chk("rstfetch.rom_index", 32'(rom_index), 32'd0);
        chk("rstfetch.sp_wrap", 32'({step_pulse, wrap}), 32'd0);
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            step(1'b0, 1'b0, 1'b0);
            seen += int'(step_pulse);
        end
        chk("rstfetch.no_pulse", 32'(seen), 32'd0);

        // Randomized traffic against the model
        step(1'b1, 1'b0, 1'b0);
        rd = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rr = ($urandom_range(0, 299) == 0);
            re = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) rd = ~rd;
            step(rr, re, rd);
            chk($sformatf("rand%0d.outputs", c),
                32'({window, rom_index, step_pulse, wrap}), 32'(model_pack()));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/message_scroller.md
MESSAGE_SCROLLER -- requirements
Module: message_scroller

Interface
REQ-001 SHALL have parameter MSG_LEN, default 10: number of characters in the message ROM, range 2..16.
REQ-002 SHALL have parameter TICK_DIV, default 3000000: clk cycles per scroll step, minimum 4.
REQ-003 SHALL have parameter BLANK, default 5'h1F: character code shown in empty digit positions.
REQ-004 SHALL have port clk  input  1  system clock; all logic on the rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port en  input  1  scroll enable; low pauses scrolling.
REQ-007 SHALL have port dir  input  1  scroll direction: 0 forward, 1 reverse.
REQ-008 SHALL have port rom_index  output  4  registered address into the combinational message ROM.
REQ-009 SHALL have port rom_value  input  5  character code returned by the ROM in the same cycle.
REQ-010 SHALL have port window  output  15  three 5-bit digits: digit2=[14:10], digit1=[9:5], digit0=[4:0].
REQ-011 SHALL have port step_pulse  output  1  one-cycle pulse when window updates.
REQ-012 SHALL have port wrap  output  1  one-cycle pulse, coincident with step_pulse, when rom_index wraps.

Function
REQ-013 Prescaler SHALL count 0..TICK_DIV-1 while en=1, hold its value while en=0, and emit a one-cycle tick when the count equals TICK_DIV-1, then return to 0.
REQ-014 FSM SHALL have states WAIT, FETCH and SHIFT.
REQ-015 FSM transitions SHALL be: WAIT->FETCH on tick; FETCH->SHIFT unconditionally; SHIFT->WAIT unconditionally.
REQ-016 In SHIFT with forward direction, window SHALL become {digit1, digit0, rom_value}, and rom_index SHALL advance to (rom_index+1) mod MSG_LEN.
REQ-017 In SHIFT with reverse direction, window SHALL become {rom_value, digit2, digit1}, and rom_index SHALL advance to (rom_index-1) mod MSG_LEN.
REQ-018 Direction SHALL be sampled in FETCH; a dir change during WAIT takes effect on the next step, with no re-fetch.
REQ-019 step_pulse SHALL assert in the cycle after SHIFT, for exactly one cycle per step.
REQ-020 wrap SHALL assert with step_pulse when rom_index moved MSG_LEN-1->0 (forward) or 0->MSG_LEN-1 (reverse).
REQ-021 A tick arriving outside WAIT SHALL be ignored; TICK_DIV>=4 guarantees this cannot occur.
REQ-022 Deasserting en during FETCH or SHIFT SHALL NOT abort the step in progress.

Reset
REQ-023 On reset=1 at a clk edge, the following SHALL take effect next cycle: state=WAIT, prescaler=0, rom_index=0, window={BLANK,BLANK,BLANK}, step_pulse=0, wrap=0.
REQ-024 Reset SHALL override any state, including a step in progress in FETCH or SHIFT.

Configuration
REQ-025 With macro MSG_SCROLL_BOUNCE_EN defined, dir SHALL be ignored and direction SHALL come from an internal bit, reset to forward.
REQ-026 With MSG_SCROLL_BOUNCE_EN defined, the internal bit SHALL toggle in SHIFT when the new rom_index reaches MSG_LEN-1 (forward) or 0 (reverse), and wrap SHALL pulse on each toggle.
REQ-027 Without MSG_SCROLL_BOUNCE_EN, direction SHALL follow dir per REQ-016..REQ-020.

Structure
REQ-028 Package msg_scroll_pkg SHALL hold the FSM state enum, CHAR_W=5, DIGITS=3 and the default BLANK.
REQ-029 The prescaler SHALL be sub-module scroll_tick_gen (ports clk, reset, en, tick; parameter TICK_DIV).

Verification (TICK_DIV=4, MSG_LEN=10, ROM returns value=index)
REQ-030 Reset asserted -> window=15'h7FFF, rom_index=0, step_pulse=0, wrap=0.
REQ-031 en=1, dir=0, 3 steps -> window=15'h0022 ({0,1,2}), rom_index=3, step_pulse every 4 cycles, wrap=0.
REQ-032 en=1, dir=0, 10 steps -> wrap pulses only with the 10th step_pulse, window={7,8,9}=15'h1D09, rom_index=0.
REQ-033 en=1, dir=1 from reset, 1 step -> window={0,BLANK,BLANK}=15'h03FF, rom_index=9, wrap=1 with step_pulse.
REQ-034 en dropped for 20 cycles mid-count -> no step_pulse during the pause; the next step lands exactly (4-count) enabled cycles later.
REQ-035 Reset asserted in FETCH -> no step_pulse follows, and all outputs hold reset values the next cycle.
